// File: rtl/shift_seq_pkg.sv
// Shared types for the sequential left-shift controller: FSM state encoding
// and the stage-counter width helper.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must index stages 0..shift_width-1 and never collapse to zero bits.
    function automatic int stage_cnt_width(input int shift_width);
        return (shift_width > 1) ? $clog2(shift_width) : 1;
    endfunction

    localparam int DEFAULT_SHIFT_WIDTH     = 5;
    localparam int DEFAULT_STAGE_CNT_WIDTH = stage_cnt_width(DEFAULT_SHIFT_WIDTH);

endpackage

// File: rtl/mux_nbit.sv
// N-bit 2:1 multiplexer: y = sel ? a : b.
module mux_nbit #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sel,
    output logic [N-1:0] y
);

    assign y = sel ? a : b;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle logarithmic left shifter: one power-of-two stage per SHIFT cycle.
// Optional macro SHIFT_SEQ_EARLY_EXIT_EN stops after the highest set amount bit.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [SHIFT_WIDTH-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_y,
    output logic                   busy
);

    localparam int KW = stage_cnt_width(SHIFT_WIDTH);

    state_t                 state_reg;
    logic [WIDTH-1:0]       data_reg;
    logic [SHIFT_WIDTH-1:0] amount_reg;
    logic [KW-1:0]          k_reg;

    logic [WIDTH-1:0]       stage_shift [SHIFT_WIDTH];
    logic [WIDTH-1:0]       shifted;
    logic [WIDTH-1:0]       stage_y;
    logic                   last_stage;
    logic                   skip_shift;

    // Each stage shifts by a fixed 2**gi; shifts past the word simply give zero.
    generate
        for (genvar gi = 0; gi < SHIFT_WIDTH; gi++) begin : g_stage
            localparam longint SH = 64'd1 << gi;
            if (SH >= WIDTH) begin : g_zero
                assign stage_shift[gi] = '0;
            end else begin : g_shl
                assign stage_shift[gi] = data_reg << SH;
            end
        end
    endgenerate

    assign shifted = stage_shift[k_reg];

    mux_nbit #(
        .N (WIDTH)
    ) u_stage_mux (
        .a   (shifted),
        .b   (data_reg),
        .sel (amount_reg[k_reg]),
        .y   (stage_y)
    );

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    // Done once no amount bit above the current stage remains set.
    assign last_stage = (k_reg == KW'(SHIFT_WIDTH - 1)) ||
                        (((amount_reg >> k_reg) >> 1) == '0);
    assign skip_shift = (in_b == '0);
`else
    assign last_stage = (k_reg == KW'(SHIFT_WIDTH - 1));
    assign skip_shift = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            k_reg      <= '0;
            data_reg   <= '0;
            amount_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        data_reg   <= in_a;
                        amount_reg <= in_b;
                        k_reg      <= '0;
                        state_reg  <= skip_shift ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    data_reg <= stage_y;
                    k_reg    <= k_reg + KW'(1);
                    if (last_stage) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = !in_ready;
    assign out_y     = data_reg;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: abstract latency/result model with a
// per-cycle compare process, directed corner cases and randomized traffic.
module tb_shift_seq_ctrl;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [SW-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_y;
    logic          busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    shift_seq_ctrl #(
        .WIDTH       (W),
        .SHIFT_WIDTH (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference result: plain left shift, zero when the amount leaves the word.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input logic [SW-1:0] b);
        if (int'(b) >= W) return '0;
        return a << b;
    endfunction

    // Cycles from the accept edge until out_valid is seen.
    function automatic int ref_lat(input logic [SW-1:0] b);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        int msb = -1;
        for (int i = 0; i < SW; i++) if (b[i]) msb = i;
        return (msb < 0) ? 1 : msb + 2;
`else
        return SW + 1;
`endif
    endfunction

    function automatic int pick(input int plain, input int early);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        return early;
`else
        return plain;
`endif
    endfunction

    // Model: phase 0 idle, 1 working, 2 result presented.
    int           m_phase = 0;
    int           m_wait  = 0;
    logic [W-1:0] m_res   = '0;
    bit           m_zero  = 1'b1;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_zero  <= 1'b1;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_res   <= ref_shift(in_a, in_b);
                    m_wait  <= ref_lat(in_b) - 1;
                    m_zero  <= 1'b0;
                    m_phase <= (ref_lat(in_b) == 1) ? 2 : 1;
                end
                1: begin
                    m_wait <= m_wait - 1;
                    if (m_wait == 1) m_phase <= 2;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
            chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            if (m_phase == 2) chk("out_y", out_y, m_res);
            else if (m_zero) chk("out_y_reset", out_y, 32'h0);
        end
    end

    task automatic wait_ready();
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'h1);
    endtask

    task automatic run_one(input logic [W-1:0] a, input logic [SW-1:0] b,
                           input logic [W-1:0] exp_y, input int exp_lat, input int stall);
        int lat;
        in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("result", out_y, exp_y);
        for (int i = 0; i < stall; i++) begin
            in_valid = (i % 2 == 0);
            in_a = $urandom; in_b = SW'($urandom);
            @(posedge clk); #1;
            chk("stall_y", out_y, exp_y);
            chk("stall_ready", 32'(in_ready), 32'h0);
            chk("stall_valid", 32'(out_valid), 32'h1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_after_hs", 32'(in_ready), 32'h1);
        chk("valid_after_hs", 32'(out_valid), 32'h0);
        $display("txn a=0x%08h b=%0d y=0x%08h lat=%0d", a, b, exp_y, lat);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_out_y", out_y, 32'h0);

        run_one(32'h0000_0001, 5'd5,  32'h0000_0020, pick(6, 4), 0);
        run_one(32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 6, 0);
        run_one(32'h1234_5678, 5'd0,  32'h1234_5678, pick(6, 1), 0);
        run_one(32'hA5A5_A5A5, 5'd3,  32'h2D2D_2D28, pick(6, 3), 3);

        // Reset while stage k=2 is in flight.
        in_a = 32'h0000_0001; in_b = 5'd31; in_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'h1);
        chk("midrst_out_y", out_y, 32'h0);
        $display("txn mid-shift reset");
        run_one(32'h0000_0003, 5'd4, 32'h0000_0030, pick(6, 4), 0);

        // Back-to-back with both valid and ready held high.
        in_a = 32'hFFFF_FFFF; in_b = 5'd31; in_valid = 1'b1; out_ready = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_a = 32'h0000_0001; in_b = 5'd5;
        n = 1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("issue_interval", 32'(n), 32'd7);
        $display("txn back-to-back interval=%0d", n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_second_y", out_y, 32'h0000_0020);
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Randomized traffic, occasional resets.
        for (int c = 0; c < 2000; c++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            in_valid  = $urandom_range(0, 1);
            in_a      = $urandom;
            in_b      = SW'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready && rst_n)
                $display("txn rnd a=0x%08h b=%0d exp=0x%08h", in_a, in_b, ref_shift(in_a, in_b));
            @(posedge clk); #1;
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits.
REQ-002 SHALL have parameter SHIFT_WIDTH, default 5: shift-amount width and number of shift stages.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: request present.
REQ-006 SHALL have port in_ready, output, 1: controller can accept a request.
REQ-007 SHALL have port in_a, input, WIDTH: operand to shift left.
REQ-008 SHALL have port in_b, input, SHIFT_WIDTH: unsigned shift amount.
REQ-009 SHALL have port out_valid, output, 1: result present.
REQ-010 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-011 SHALL have port out_y, output, WIDTH: shifted result.
REQ-012 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, SHIFT and DONE.
REQ-014 SHALL drive in_ready = (state == IDLE), out_valid = (state == DONE) and busy = !in_ready.
REQ-015 SHALL, on accept (in_valid && in_ready), latch in_a into a data register and in_b into an amount register, clear stage counter k to 0, and enter SHIFT.
REQ-016 SHALL, in each SHIFT cycle, load data << (1 << k) into the data register when amount bit k is 1, hold it otherwise, then increment k.
REQ-017 SHALL leave SHIFT for DONE after stage k = SHIFT_WIDTH-1, so that out_valid rises SHIFT_WIDTH+1 cycles after the accept edge.
REQ-018 SHALL zero-fill from the LSB and discard bits shifted past WIDTH-1; amounts >= WIDTH SHALL yield 0.
REQ-019 SHALL, in DONE, hold out_y and out_valid stable until out_ready is 1, then return to IDLE on that edge.
REQ-020 SHALL NOT accept a new request in the same cycle as an output handshake; the next accept is possible one cycle later, so the minimum issue interval is SHIFT_WIDTH+2 cycles.
REQ-021 SHALL ignore in_valid, in_a and in_b while busy, and SHALL ignore out_ready while not in DONE.
REQ-022 SHALL drive out_y from the data register in every state; its value is meaningful only while out_valid is 1.

Reset
REQ-023 SHALL, on any rising edge with rst_n = 0, force state IDLE, k = 0, and clear the data and amount registers to 0, in any state including mid-SHIFT and DONE.
REQ-024 SHALL, after that reset edge, present out_valid = 0, busy = 0, in_ready = 1 and out_y = 0; any in-flight result is dropped.

Configuration
REQ-025 SHALL support macro SHIFT_SEQ_EARLY_EXIT_EN.
REQ-026 SHALL, with SHIFT_SEQ_EARLY_EXIT_EN defined, go from accept directly to DONE when in_b = 0 (out_valid one cycle after accept).
REQ-027 SHALL, with SHIFT_SEQ_EARLY_EXIT_EN defined, leave SHIFT for DONE after the stage that processes the highest set bit of the amount, giving latency (msb_index + 2) cycles.
REQ-028 SHALL, without SHIFT_SEQ_EARLY_EXIT_EN, always run all SHIFT_WIDTH stages (REQ-017); results SHALL be identical in both builds.

Structure
REQ-029 SHALL take the state enumeration and the stage-counter width ($clog2(SHIFT_WIDTH), minimum 1) from shared package shift_seq_pkg.
REQ-030 SHALL perform each stage with one instance of the existing mux_nbit sub-module, with A = data << (1 << k), B = data and sel = amount[k]; no full combinational barrel shifter SHALL be instantiated.

Verification (WIDTH=32, SHIFT_WIDTH=5)
REQ-031 SHALL cover: in_a=0x00000001, in_b=5 -> out_y=0x00000020; out_valid at accept+6 (accept+4 with SHIFT_SEQ_EARLY_EXIT_EN).
REQ-032 SHALL cover: in_a=0xFFFFFFFF, in_b=31 -> out_y=0x80000000 at accept+6 in both builds.
REQ-033 SHALL cover: in_a=0x12345678, in_b=0 -> out_y=0x12345678 at accept+6 (accept+1 with the macro).
REQ-034 SHALL cover: out_ready held 0 for 3 cycles in DONE, with new in_valid pulses -> out_y stable, in_ready 0, no extra accept; release -> IDLE next cycle.
REQ-035 SHALL cover: rst_n=0 for one edge during stage k=2 -> next cycle out_valid=0, in_ready=1, out_y=0; a following in_a=0x3, in_b=4 yields 0x30.
REQ-036 SHALL cover: in_valid and out_ready held 1 with two back-to-back requests -> second accept exactly one cycle after the first output handshake, giving a 7-cycle issue interval without the macro.
